// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the ROM-load write path between game_loader and
//   the SDRAM controller.
//   - LOADER_ADDR_BITS / SDRAM_ADDR_BITS : default address widths
//   - NES_SLOT_PHASE                     : nes_ce value marking a slot edge
//   - loader_wr_t                        : one buffered byte write {addr, data}
package loader_pkg;

    localparam int LOADER_ADDR_BITS = 22;
    localparam int SDRAM_ADDR_BITS  = 25;

    localparam logic [1:0] NES_SLOT_PHASE = 2'd3;

    typedef struct packed {
        logic [LOADER_ADDR_BITS-1:0] addr;
        logic [7:0]                  data;
    } loader_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Generic single-clock FIFO with asynchronous active-high reset.
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate counter.
//   Ports:
//     clock, reset : clock and async reset (clears pointers)
//     push, din    : write request and data; ignored when full unless a pop
//                    happens on the same edge
//     pop, dout    : read request and current head (combinational)
//     full, empty  : occupancy flags
//     level        : number of stored entries
module sync_fifo #(
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 4,
    localparam int PTR_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    din,
    output logic [WIDTH-1:0]    dout,
    output logic                full,
    output logic                empty,
    output logic [PTR_BITS-1:0] level
);

    localparam int IDX_BITS = PTR_BITS - 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_BITS-1] != r_rd_ptr[PTR_BITS-1]) &&
                   (r_wr_ptr[IDX_BITS-1:0] == r_rd_ptr[IDX_BITS-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[IDX_BITS-1:0]];

    // A pop on the same edge frees the slot the push lands in, so a full
    // FIFO still accepts the write; the head is read before it is replaced.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[IDX_BITS-1:0]] <= din;
    end

endmodule

// File: rtl/loader_write_bridge.sv
// loader_write_bridge
//   Buffers game_loader byte writes and replays them to the SDRAM port, one
//   per NES slot, aligned to the slot edge (nes_ce == NES_SLOT_PHASE).
//   Ports:
//     clock, reset       : system clock, async active-high reset
//     nes_ce             : free-running NES phase counter
//     in_write/addr/data : single-cycle byte write from game_loader
//     mem_addr/din/we    : registered SDRAM write request, held for one slot
//     level              : FIFO occupancy
//     idle               : nothing queued and no write in flight
//     overflow           : sticky, set when a write had to be dropped
//   Entry addresses are carried as LOADER_ADDR_BITS wide; ADDR_BITS is
//   expected not to exceed that width.
module loader_write_bridge #(
    parameter int  ADDR_BITS       = loader_pkg::LOADER_ADDR_BITS,
    parameter int  DEPTH           = 4,
    parameter int  SDRAM_ADDR_BITS = loader_pkg::SDRAM_ADDR_BITS,
    localparam int LEVEL_BITS      = $clog2(DEPTH) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 nes_ce,
    input  logic                       in_write,
    input  logic [ADDR_BITS-1:0]       in_addr,
    input  logic [7:0]                 in_data,
    output logic [SDRAM_ADDR_BITS-1:0] mem_addr,
    output logic [7:0]                 mem_din,
    output logic                       mem_we,
    output logic [LEVEL_BITS-1:0]      level,
    output logic                       idle,
    output logic                       overflow
);

    import loader_pkg::*;

    loader_wr_t                 w_push_entry;
    loader_wr_t                 w_head;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_slot;
    logic                       w_pop;
    logic [LEVEL_BITS-1:0]      w_level;

    logic [SDRAM_ADDR_BITS-1:0] r_mem_addr;
    logic [7:0]                 r_mem_din;
    logic                       r_mem_we;
    logic                       r_overflow;

    assign w_slot       = (nes_ce == NES_SLOT_PHASE);
    // The emptiness seen here is from before this edge's push, so a write
    // arriving on a slot edge into an empty FIFO waits for the next slot.
    assign w_pop        = w_slot && !w_empty;
    assign w_push_entry = '{addr: LOADER_ADDR_BITS'(in_addr), data: in_data};

    sync_fifo #(
        .WIDTH ($bits(loader_wr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_write),
        .pop   (w_pop),
        .din   (w_push_entry),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Outputs only change on a slot edge, so each request is held for a
    // whole slot and back-to-back entries keep mem_we high throughout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
        end else if (w_slot) begin
            if (!w_empty) begin
                r_mem_addr <= SDRAM_ADDR_BITS'(w_head.addr);
                r_mem_din  <= w_head.data;
                r_mem_we   <= 1'b1;
            end else begin
                r_mem_we   <= 1'b0;
            end
        end
    end

    // A push into a full FIFO is only lost when no pop frees a slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (in_write && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;
    assign level    = w_level;
    assign idle     = w_empty && !r_mem_we;
    assign overflow = r_overflow;

endmodule
